// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battle_pkg
// Brief    : Shared game types: tank direction and enemy AI state encodings.
// Revision : 1.0
// ============================================================================
package battle_pkg;

  localparam int HOLD_W = 9;
  localparam int FIRE_W = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MOVE  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_TURN  = 2'b11
  } enemy_state_t;

  // Clockwise quarter turn; LEFT wraps to UP.
  function automatic dir_t dir_cw(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_down_counter
// Brief    : Loadable per-frame down counter with zero / last-frame flags.
// Revision : 1.0
// ============================================================================
module frame_down_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/enemy_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enemy_dir_ctrl
// Brief    : Enemy tank AI: timed wandering, collision pause/turn, periodic fire.
// Revision : 1.0
// ============================================================================
module enemy_dir_ctrl
  import battle_pkg::*;
#(
  parameter int MIN_HOLD     = 32,
  parameter int PAUSE_FRAMES = 8,
  parameter int FIRE_BASE    = 60
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [8:0] rand_in,
  input  logic       blocked,
  input  logic       fire_ack,
  output logic [1:0] dir,
  output logic       move_en,
  output logic       fire_req
);

  localparam logic [HOLD_W-1:0] c_min_hold  = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] c_pause     = HOLD_W'(PAUSE_FRAMES);
  localparam logic [FIRE_W-1:0] c_fire_base = FIRE_W'(FIRE_BASE);

  enemy_state_t      state_q, state_d;
  dir_t              dir_q, dir_d;
  logic              move_en_q, move_en_d;
  logic              fire_req_q, fire_req_d;
  logic              from_pause_q, from_pause_d;
  logic [FIRE_W-1:0] fire_cnt_q, fire_cnt_d;

  logic              w_hold_load, w_hold_tick, w_hold_zero, w_hold_last, w_hold_expire;
  logic              w_pause_load, w_pause_tick, w_pause_zero, w_pause_last, w_pause_expire;
  logic [HOLD_W-1:0] w_hold_init;
  logic [FIRE_W-1:0] w_fire_thr, w_fire_inc;

  assign w_hold_init  = c_min_hold + {3'b000, rand_in[5:0]};
  assign w_fire_thr   = c_fire_base + {rand_in[8:6], 3'b000};
  assign w_fire_inc   = fire_cnt_q + FIRE_W'(1);

  assign w_hold_load  = enable && (((state_q == ST_IDLE) && frame_tick) || (state_q == ST_TURN));
  assign w_hold_tick  = enable && frame_tick && (state_q == ST_MOVE);
  assign w_pause_load = w_hold_tick && blocked;
  assign w_pause_tick = enable && frame_tick && (state_q == ST_PAUSE);

  // A zero count is treated as expired so degenerate parameters cannot stall.
  assign w_hold_expire  = w_hold_last | w_hold_zero;
  assign w_pause_expire = w_pause_last | w_pause_zero;

  frame_down_counter #(.W(HOLD_W)) u_hold (
    .clk      (Clk),
    .rst      (reset),
    .clear    (!enable),
    .load     (w_hold_load),
    .load_val (w_hold_init),
    .tick     (w_hold_tick),
    .zero     (w_hold_zero),
    .last     (w_hold_last)
  );

  frame_down_counter #(.W(HOLD_W)) u_pause (
    .clk      (Clk),
    .rst      (reset),
    .clear    (!enable),
    .load     (w_pause_load),
    .load_val (c_pause),
    .tick     (w_pause_tick),
    .zero     (w_pause_zero),
    .last     (w_pause_last)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_DOWN;
      move_en_q    <= 1'b0;
      fire_req_q   <= 1'b0;
      from_pause_q <= 1'b0;
      fire_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      move_en_q    <= move_en_d;
      fire_req_q   <= fire_req_d;
      from_pause_q <= from_pause_d;
      fire_cnt_q   <= fire_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (frame_tick) state_d = ST_MOVE;
        ST_MOVE: begin
          // Collision takes priority over a coincident hold expiry.
          if (frame_tick && blocked)            state_d = ST_PAUSE;
          else if (frame_tick && w_hold_expire) state_d = ST_TURN;
        end
        ST_PAUSE: if (frame_tick && w_pause_expire) state_d = ST_TURN;
        ST_TURN:  state_d = ST_MOVE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_d        = dir_q;
    from_pause_d = from_pause_q;
    fire_cnt_d   = fire_cnt_q;
    fire_req_d   = fire_req_q;
    move_en_d    = (state_d == ST_MOVE);

    if (enable && (state_q == ST_TURN)) begin
      dir_d = dir_t'(rand_in[1:0]);
      // After a collision never pick the direction we were blocked in.
      if (from_pause_q && (dir_d == dir_q)) dir_d = dir_cw(dir_q);
    end
    if (state_d == ST_TURN) from_pause_d = (state_q == ST_PAUSE);

    if (!enable) begin
      fire_cnt_d = '0;
      fire_req_d = 1'b0;
    end else if (fire_req_q) begin
      if (fire_ack) fire_req_d = 1'b0;
    end else if ((state_q == ST_MOVE) && frame_tick) begin
      if (w_fire_inc == w_fire_thr) begin
        fire_req_d = 1'b1;
        fire_cnt_d = '0;
      end else begin
        fire_cnt_d = w_fire_inc;
      end
    end
  end

  assign dir      = dir_q;
  assign move_en  = move_en_q;
  assign fire_req = fire_req_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_dir_ctrl
// Brief    : Directed scoreboard bench for enemy_dir_ctrl (default parameters).
// Revision : 1.0
// ============================================================================
module tb_enemy_dir_ctrl;

  logic       Clk;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic [8:0] rand_in;
  logic       blocked;
  logic       fire_ack;
  logic [1:0] dir;
  logic       move_en;
  logic       fire_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] dir;
    logic       move_en;
    logic       fire_req;
  } exp_t;

  exp_t sb_q[$];

  enemy_dir_ctrl dut (
    .Clk        (Clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .rand_in    (rand_in),
    .blocked    (blocked),
    .fire_ack   (fire_ack),
    .dir        (dir),
    .move_en    (move_en),
    .fire_req   (fire_req)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] d, input logic m, input logic f);
    exp_t e;
    e.tag      = tag;
    e.dir      = d;
    e.move_en  = m;
    e.fire_req = f;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed output with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    assert ({dir, move_en, fire_req} === {e.dir, e.move_en, e.fire_req})
    else begin
      errors++;
      $error("FAIL %s: observed dir=%b move_en=%b fire_req=%b expected dir=%b move_en=%b fire_req=%b",
             e.tag, dir, move_en, fire_req, e.dir, e.move_en, e.fire_req);
    end
  endtask

  // One clock: drive frame_tick, queue the expected registered outputs, then compare.
  task automatic cyc(input string tag, input logic tick, input logic [1:0] d,
                     input logic m, input logic f);
    frame_tick = tick;
    expect_out(tag, d, m, f);
    step();
    frame_tick = 1'b0;
    check_out();
  endtask

  // n frames, each a tick cycle followed by a quiet cycle.
  task automatic frames(input string tag, input int n, input logic [1:0] d, input logic m);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b1, d, m, 1'b0);
      cyc(tag, 1'b0, d, m, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    frame_tick = 1'b1;
    blocked    = 1'b0;
    fire_ack   = 1'b1;
    rand_in    = 9'h005;
    step();
    step();
    cyc("reset_override", 1'b1, 2'b10, 1'b0, 1'b0);
    reset    = 1'b0;
    fire_ack = 1'b0;

    // Enter MOVE, hold = 32 + 5 = 37 ticks
    cyc("idle_no_tick", 1'b0, 2'b10, 1'b0, 1'b0);
    cyc("enter_move",   1'b1, 2'b10, 1'b1, 1'b0);
    frames("hold_count", 36, 2'b10, 1'b1);
    rand_in = 9'h003;
    cyc("hold_expire_turn", 1'b1, 2'b10, 1'b0, 1'b0);
    cyc("turn_to_move",     1'b0, 2'b11, 1'b1, 1'b0);

    // Collision while facing left, random pick also left -> wrap to up
    blocked = 1'b1;
    cyc("blocked_pause", 1'b1, 2'b11, 1'b0, 1'b0);
    blocked = 1'b0;
    cyc("pause_quiet", 1'b0, 2'b11, 1'b0, 1'b0);
    frames("pause_count", 7, 2'b11, 1'b0);
    cyc("pause_expire",    1'b1, 2'b11, 1'b0, 1'b0);
    cyc("pause_turn_wrap", 1'b0, 2'b00, 1'b1, 1'b0);

    // Blocked on the same tick the hold expires (hold = 32)
    enable = 1'b0;
    cyc("disable_idle", 1'b0, 2'b00, 1'b0, 1'b0);
    enable  = 1'b1;
    rand_in = 9'h1C0;
    cyc("reenter_move", 1'b1, 2'b00, 1'b1, 1'b0);
    frames("hold_31", 31, 2'b00, 1'b1);
    blocked = 1'b1;
    cyc("block_beats_expiry", 1'b1, 2'b00, 1'b0, 1'b0);
    blocked = 1'b0;
    cyc("no_immediate_turn", 1'b0, 2'b00, 1'b0, 1'b0);
    frames("pause2_count", 7, 2'b00, 1'b0);
    cyc("pause2_expire",  1'b1, 2'b00, 1'b0, 1'b0);
    cyc("pause_turn_inc", 1'b0, 2'b01, 1'b1, 1'b0);

    // Fire interval 60 + 16 = 76 MOVE ticks; hold 32 + 63 = 95
    enable = 1'b0;
    cyc("disable2", 1'b0, 2'b01, 1'b0, 1'b0);
    enable  = 1'b1;
    rand_in = 9'h0BF;
    cyc("move3", 1'b1, 2'b01, 1'b1, 1'b0);
    frames("fire_count", 75, 2'b01, 1'b1);
    cyc("fire_req_set", 1'b1, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc("fire_req_held", 1'b0, 2'b01, 1'b1, 1'b1);
    fire_ack = 1'b1;
    cyc("fire_ack_drop",     1'b0, 2'b01, 1'b1, 1'b0);
    cyc("stray_ack_ignored", 1'b0, 2'b01, 1'b1, 1'b0);
    fire_ack = 1'b0;

    // Second shot, with a random turn (hold 19 left) in the middle of the interval
    frames("fire2_a", 18, 2'b01, 1'b1);
    cyc("fire2_turn", 1'b1, 2'b01, 1'b0, 1'b0);
    cyc("fire2_move", 1'b0, 2'b11, 1'b1, 1'b0);
    frames("fire2_b", 56, 2'b11, 1'b1);
    cyc("fire2_set", 1'b1, 2'b11, 1'b1, 1'b1);
    enable = 1'b0;
    cyc("disable_with_fire", 1'b0, 2'b11, 1'b0, 1'b0);
    enable = 1'b1;

    // Reset in the middle of a pause, together with a frame tick
    rand_in = 9'h005;
    cyc("move4", 1'b1, 2'b11, 1'b1, 1'b0);
    blocked = 1'b1;
    cyc("pause4", 1'b1, 2'b11, 1'b0, 1'b0);
    blocked = 1'b0;
    frames("pause4_count", 2, 2'b11, 1'b0);
    reset    = 1'b1;
    fire_ack = 1'b1;
    cyc("reset_mid_pause", 1'b1, 2'b10, 1'b0, 1'b0);
    reset    = 1'b0;
    fire_ack = 1'b0;
    cyc("post_reset_idle", 1'b0, 2'b10, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enemy_dir_ctrl.md
ENEMY_DIR_CTRL -- requirements
Module: enemy_dir_ctrl

Interface
REQ-001 SHALL have parameter MIN_HOLD, default 32, minimum frames an enemy holds one direction.
REQ-002 SHALL have parameter PAUSE_FRAMES, default 8, frames spent stopped after a collision.
REQ-003 SHALL have parameter FIRE_BASE, default 60, base frame interval between shots.
REQ-004 SHALL have port Clk  input  1  sole clock; all logic on posedge Clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1  one-Clk pulse per video frame.
REQ-007 SHALL have port enable  input  1  tank alive/active.
REQ-008 SHALL have port rand_in  input  9  pseudo-random word from the LFSR block; stable for at least one Clk.
REQ-009 SHALL have port blocked  input  1  tank collided with wall/tank this frame.
REQ-010 SHALL have port fire_ack  input  1  bullet logic accepted the shot.
REQ-011 SHALL have port dir  output  2  00 up, 01 right, 10 down, 11 left.
REQ-012 SHALL have port move_en  output  1  tank advances one step per frame while high.
REQ-013 SHALL have port fire_req  output  1  shot request, held until acknowledged.

Function
REQ-014 SHALL implement states IDLE, MOVE, PAUSE, TURN; all outputs registered.
REQ-015 IDLE: move_en=0; on enable=1 and frame_tick, load hold=MIN_HOLD+rand_in[5:0] (9-bit), go MOVE.
REQ-016 MOVE: move_en=1; on each frame_tick decrement hold; tick with hold==1 -> TURN.
REQ-017 MOVE: blocked=1 on a frame_tick -> PAUSE, load pause=PAUSE_FRAMES, move_en=0 next cycle.
REQ-018 Simultaneous blocked and hold expiry on the same tick: blocked wins (PAUSE).
REQ-019 PAUSE: move_en=0; decrement pause on frame_tick; tick with pause==1 -> TURN.
REQ-020 TURN: exactly one Clk; dir<=rand_in[1:0]; if entered from PAUSE and rand_in[1:0]==dir, dir<=dir+1 mod 4 (11 wraps to 00); reload hold as REQ-015; go MOVE.
REQ-021 Fire counter SHALL count frame_ticks only in MOVE; on reaching FIRE_BASE+{rand_in[8:6],3'b000} (8-bit) assert fire_req and clear counter.
REQ-022 fire_req SHALL stay high until fire_ack sampled high, then drop next Clk; at most one outstanding request; counter does not run while fire_req=1.
REQ-023 fire_ack while fire_req=0 SHALL be ignored.
REQ-024 enable=0 in any state -> IDLE next Clk; move_en=0, fire_req=0, counters cleared; dir retained.
REQ-025 frame_tick absent: no counter or state change except TURN->MOVE and enable handling.

Reset
REQ-026 reset=1 SHALL force state IDLE, dir=10 (down), move_en=0, fire_req=0, hold/pause/fire counters=0.
REQ-027 reset SHALL override enable, frame_tick and fire_ack in the same cycle; mid-move reset behaves identically.

Structure
REQ-028 Direction enum (dir_t) and state enum SHALL live in the shared game package battle_pkg.
REQ-029 Hold/pause countdown SHALL be one sub-module frame_down_counter (load, tick, zero flag), instantiated twice.

Verification
REQ-030 Reset then enable=1, rand_in=9'h005, frame_tick -> MOVE, move_en=1 next cycle, dir=10, turn after exactly 37 ticks.
REQ-031 In MOVE, blocked=1 on tick, rand_in[1:0]=dir=11 -> move_en=0 for 8 ticks, then dir=00 (wrap).
REQ-032 blocked and hold expiry on same tick -> PAUSE entered, not immediate TURN.
REQ-033 rand_in[8:6]=3'b010, FIRE_BASE=60 -> fire_req after 76 MOVE ticks; held 5 cycles until fire_ack; drops next Clk.
REQ-034 enable=0 while fire_req=1 in MOVE -> IDLE, fire_req=0, move_en=0 next Clk, dir unchanged.
REQ-035 reset asserted mid-PAUSE with frame_tick -> all outputs at reset values next Clk.
